// File: rtl/ball_split_dispatcher.sv
`default_nettype none
// ============================================================================
// Module  : ball_split_dispatcher
// Purpose : Queues ball-hit events and splits each hit ball into two smaller
//           children assigned to free slots, or pops the smallest size.
// Revision: 1.0  initial release
// ============================================================================
module ball_split_dispatcher #(
  parameter int NUM_BALLS  = 8,
  parameter int SIZE_W     = 2,
  parameter int COORD_W    = 11,
  parameter int X_MAX      = 639,
  parameter int SPLIT_OFS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         hit_valid,
  output logic                         hit_ready,
  input  logic [COORD_W-1:0]           hit_x,
  input  logic [COORD_W-1:0]           hit_y,
  input  logic [SIZE_W-1:0]            hit_size,
  input  logic [NUM_BALLS-1:0]         available,
  output logic                         spawn_valid,
  output logic [$clog2(NUM_BALLS)-1:0] spawn_idx,
  output logic [COORD_W-1:0]           spawn_x,
  output logic [COORD_W-1:0]           spawn_y,
  output logic [SIZE_W-1:0]            spawn_size,
  output logic                         spawn_dir,
  output logic                         pop_pulse,
  output logic                         drop_pulse
);

  localparam int IDX_W = $clog2(NUM_BALLS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * COORD_W + SIZE_W;

  localparam logic [COORD_W-1:0] c_ofs      = COORD_W'(SPLIT_OFS);
  localparam logic [COORD_W:0]   c_xmax_ext = (COORD_W + 1)'(X_MAX);
  localparam logic [CNT_W-1:0]   c_full     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN_L = 2'd1,
    ST_SCAN_R = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // ---------------- pending-hit queue ----------------
  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push, w_pop;
  logic [COORD_W-1:0] w_head_x, w_head_y;
  logic [SIZE_W-1:0]  w_head_size;

  assign hit_ready = (r_count != c_full);
  assign w_push    = hit_valid && hit_ready;
  assign {w_head_x, w_head_y, w_head_size} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {hit_x, hit_y, hit_size};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- work registers and slot search ----------------
  logic [COORD_W-1:0]   r_wx, r_wy;
  logic [SIZE_W-1:0]    r_wsize;
  logic [NUM_BALLS-1:0] r_reserved, w_res_set, w_free;
  logic                 w_found;
  logic [IDX_W-1:0]     w_free_idx;
  logic [COORD_W-1:0]   w_left_x, w_right_x;
  logic [COORD_W:0]     w_sum;

  assign w_free = available & ~r_reserved;

  // Descending walk so the lowest free index is the one left standing.
  always_comb begin
    w_found    = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_found    = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_left_x  = (r_wx >= c_ofs) ? (r_wx - c_ofs) : '0;
  assign w_sum     = {1'b0, r_wx} + {1'b0, c_ofs};
  assign w_right_x = (w_sum > c_xmax_ext) ? c_xmax_ext[COORD_W-1:0] : w_sum[COORD_W-1:0];

  // ---------------- registered outputs ----------------
  logic               r_spawn_valid, r_pop_pulse, r_drop_pulse, r_dir;
  logic [IDX_W-1:0]   r_idx;
  logic [COORD_W-1:0] r_x, r_y;
  logic [SIZE_W-1:0]  r_size;

  logic               w_sv_nxt, w_pop_nxt, w_drop_nxt, w_dir_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [COORD_W-1:0] w_x_nxt, w_y_nxt;
  logic [SIZE_W-1:0]  w_size_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_sv_nxt    = 1'b0;
    w_pop_nxt   = 1'b0;
    w_drop_nxt  = 1'b0;
    w_idx_nxt   = r_idx;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_size_nxt  = r_size;
    w_dir_nxt   = r_dir;
    w_res_set   = '0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head_size == '0) w_pop_nxt   = 1'b1;
          else                   w_state_nxt = ST_SCAN_L;
        end
      end
      ST_SCAN_L, ST_SCAN_R: begin
        if (w_found) begin
          w_sv_nxt   = 1'b1;
          w_idx_nxt  = w_free_idx;
          w_dir_nxt  = (r_state == ST_SCAN_R);
          w_x_nxt    = (r_state == ST_SCAN_R) ? w_right_x : w_left_x;
          w_y_nxt    = r_wy;
          w_size_nxt = r_wsize - SIZE_W'(1);
          w_res_set  = NUM_BALLS'(1) << w_free_idx;
        end else begin
          w_drop_nxt = 1'b1;
        end
        w_state_nxt = (r_state == ST_SCAN_L) ? ST_SCAN_R : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= ST_IDLE;
      r_wx          <= '0;
      r_wy          <= '0;
      r_wsize       <= '0;
      r_reserved    <= '0;
      r_spawn_valid <= 1'b0;
      r_pop_pulse   <= 1'b0;
      r_drop_pulse  <= 1'b0;
      r_idx         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_size        <= '0;
      r_dir         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_wx    <= w_head_x;
        r_wy    <= w_head_y;
        r_wsize <= w_head_size;
      end
      // A controller dropping 'available' releases the reservation; a new set wins.
      r_reserved    <= (r_reserved & available) | w_res_set;
      r_spawn_valid <= w_sv_nxt;
      r_pop_pulse   <= w_pop_nxt;
      r_drop_pulse  <= w_drop_nxt;
      r_idx         <= w_idx_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_size        <= w_size_nxt;
      r_dir         <= w_dir_nxt;
    end
  end

  assign spawn_valid = r_spawn_valid;
  assign spawn_idx   = r_idx;
  assign spawn_x     = r_x;
  assign spawn_y     = r_y;
  assign spawn_size  = r_size;
  assign spawn_dir   = r_dir;
  assign pop_pulse   = r_pop_pulse;
  assign drop_pulse  = r_drop_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ball_split_dispatcher.sv
`default_nettype none
// ============================================================================
// Module  : tb_ball_split_dispatcher
// Purpose : Self-checking bench: directed table, corner sequences and random
//           traffic against an event-timeline reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_ball_split_dispatcher;

  localparam int NB = 8, SW = 2, CW = 11, XMAX = 639, OFS = 16, DEPTH = 4;

  logic          clk = 1'b0, resetN = 1'b0, hit_valid = 1'b0;
  logic [CW-1:0] hit_x = '0, hit_y = '0;
  logic [SW-1:0] hit_size = '0;
  logic [NB-1:0] available = '0;
  logic          hit_ready, spawn_valid, spawn_dir, pop_pulse, drop_pulse;
  logic [2:0]    spawn_idx;
  logic [CW-1:0] spawn_x, spawn_y;
  logic [SW-1:0] spawn_size;

  ball_split_dispatcher #(
    .NUM_BALLS(NB), .SIZE_W(SW), .COORD_W(CW), .X_MAX(XMAX),
    .SPLIT_OFS(OFS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetN(resetN), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_x(hit_x), .hit_y(hit_y), .hit_size(hit_size), .available(available),
    .spawn_valid(spawn_valid), .spawn_idx(spawn_idx), .spawn_x(spawn_x),
    .spawn_y(spawn_y), .spawn_size(spawn_size), .spawn_dir(spawn_dir),
    .pop_pulse(pop_pulse), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending hits as a queue, each split scheduled as two
  // timed child events, slot choice from the available/reserved bit sets.
  typedef struct { int x; int y; int sz; } hit_t;
  hit_t    m_q[$];
  hit_t    m_work;
  int      m_t, m_next_pop, m_left_t, m_right_t;
  logic [NB-1:0] m_res;
  int      e_sv, e_pop, e_drop, e_idx, e_x, e_y, e_size, e_dir;

  task automatic model_reset();
    m_q.delete();
    m_t = 0; m_next_pop = 0; m_left_t = -10; m_right_t = -10; m_res = '0;
    e_sv = 0; e_pop = 0; e_drop = 0; e_idx = 0; e_x = 0; e_y = 0; e_size = 0; e_dir = 0;
  endtask

  task automatic tick();
    logic [NB-1:0] setb;
    int   lo;
    bit   push;
    hit_t h;
    check("hit_ready", hit_ready, (m_q.size() != DEPTH));
    push   = hit_valid && (m_q.size() != DEPTH);
    e_sv   = 0; e_pop = 0; e_drop = 0; setb = '0;
    if (m_t == m_left_t || m_t == m_right_t) begin
      lo = -1;
      for (int i = NB - 1; i >= 0; i--) if (available[i] && !m_res[i]) lo = i;
      if (lo >= 0) begin
        e_sv   = 1;
        e_idx  = lo;
        e_dir  = (m_t == m_right_t) ? 1 : 0;
        e_x    = e_dir ? ((m_work.x + OFS > XMAX) ? XMAX : m_work.x + OFS)
                       : ((m_work.x < OFS) ? 0 : m_work.x - OFS);
        e_y    = m_work.y;
        e_size = m_work.sz - 1;
        setb[lo] = 1'b1;
      end else begin
        e_drop = 1;
      end
    end
    if (m_t >= m_next_pop && m_q.size() > 0) begin
      h = m_q.pop_front();
      if (h.sz == 0) begin
        e_pop = 1; m_next_pop = m_t + 1;
      end else begin
        m_work = h; m_left_t = m_t + 1; m_right_t = m_t + 2; m_next_pop = m_t + 3;
      end
    end
    if (push) m_q.push_back('{int'(hit_x), int'(hit_y), int'(hit_size)});
    m_res = (m_res & available) | setb;
    m_t++;
    @(posedge clk); #1;
    check("spawn_valid", spawn_valid, e_sv);
    check("pop_pulse",   pop_pulse,   e_pop);
    check("drop_pulse",  drop_pulse,  e_drop);
    check("spawn_idx",   spawn_idx,   e_idx);
    check("spawn_x",     spawn_x,     e_x);
    check("spawn_y",     spawn_y,     e_y);
    check("spawn_size",  spawn_size,  e_size);
    check("spawn_dir",   spawn_dir,   e_dir);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #2;
    check("rst_spawn_valid", spawn_valid, 0);
    check("rst_pop", pop_pulse, 0);
    check("rst_drop", drop_pulse, 0);
    check("rst_data", {spawn_idx, spawn_x, spawn_y, spawn_size, spawn_dir}, 0);
    check("rst_hit_ready", hit_ready, 1);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int x; int y; int sz; logic [NB-1:0] av; int pop;
    int lv; int ld; int lidx; int lx;
    int rv; int rd; int ridx; int rx;
  } vec_t;
  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   drops, accepted, saw_full, spawns;
    //         x    y  sz  av     pop lv ld li lx   rv rd ri rx
    vt[0] = '{100, 50, 2, 8'hFF, 0,  1, 0, 0, 84,  1, 0, 1, 116};
    vt[1] = '{5,   7,  1, 8'hFF, 0,  1, 0, 0, 0,   1, 0, 1, 21};
    vt[2] = '{630, 9,  3, 8'h10, 0,  1, 0, 4, 614, 0, 1, 0, 0};
    vt[3] = '{200, 1,  1, 8'h00, 0,  0, 1, 0, 0,   0, 1, 0, 0};
    vt[4] = '{16,  3,  2, 8'hA0, 0,  1, 0, 5, 0,   1, 0, 7, 32};
    vt[5] = '{624, 4,  1, 8'h03, 0,  1, 0, 0, 608, 1, 0, 1, 639};
    vt[6] = '{100, 60, 0, 8'hFF, 1,  0, 0, 0, 0,   0, 0, 0, 0};

    model_reset();
    do_reset();

    // Directed table: one hit at a time, outcomes checked at exact edges.
    foreach (vt[k]) begin
      available = '0; hit_valid = 1'b0;
      tick(); tick();
      available = vt[k].av;
      hit_valid = 1'b1; hit_x = CW'(vt[k].x); hit_y = CW'(vt[k].y); hit_size = SW'(vt[k].sz);
      tick();                                 // E0 accept
      hit_valid = 1'b0;
      tick();                                 // E1 pop
      check("vec_pop_E1", pop_pulse, vt[k].pop);
      tick();                                 // E2 left child
      check("vec_left_valid", spawn_valid, vt[k].lv);
      check("vec_left_drop", drop_pulse, vt[k].ld);
      if (vt[k].lv != 0) begin
        check("vec_left_idx", spawn_idx, vt[k].lidx);
        check("vec_left_x", spawn_x, vt[k].lx);
        check("vec_left_y", spawn_y, vt[k].y);
        check("vec_left_size", spawn_size, vt[k].sz - 1);
        check("vec_left_dir", spawn_dir, 0);
      end
      tick();                                 // E3 right child
      check("vec_right_valid", spawn_valid, vt[k].rv);
      check("vec_right_drop", drop_pulse, vt[k].rd);
      if (vt[k].rv != 0) begin
        check("vec_right_idx", spawn_idx, vt[k].ridx);
        check("vec_right_x", spawn_x, vt[k].rx);
        check("vec_right_dir", spawn_dir, 1);
      end
      tick();
      check("vec_quiet_E4", {spawn_valid, drop_pulse, pop_pulse}, 0);
    end

    // Back-to-back hits with no free slots: queue fills, every child drops.
    available = '0; drops = 0; accepted = 0; saw_full = 0;
    for (int c = 0; c < 100 && accepted < 10; c++) begin
      hit_valid = 1'b1; hit_x = CW'($urandom_range(0, 700)); hit_y = CW'(c); hit_size = 2'd1;
      if (hit_ready) accepted++; else saw_full = 1;
      tick();
      drops += drop_pulse;
    end
    hit_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin tick(); drops += drop_pulse; end
    check("b2b_accepted", accepted, 10);
    check("b2b_full_seen", saw_full, 1);
    check("b2b_drops", drops, 20);

    // Reset between the left and right child, with a second hit still queued.
    available = '0; tick();
    available = 8'hFF;
    hit_valid = 1'b1; hit_x = 11'd300; hit_y = 11'd20; hit_size = 2'd2;
    tick();                                   // E0
    hit_x = 11'd400;
    tick();                                   // E1: pop first, queue second
    hit_valid = 1'b0;
    tick();                                   // E2: left child visible
    check("mid_left_seen", spawn_valid, 1);
    do_reset();
    spawns = 0;
    for (int c = 0; c < 8; c++) begin tick(); spawns += spawn_valid + pop_pulse + drop_pulse; end
    check("mid_reset_no_activity", spawns, 0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      hit_valid = ($urandom_range(0, 2) == 0);
      hit_x     = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 660));
      hit_y     = CW'($urandom);
      hit_size  = SW'($urandom);
      if ($urandom_range(0, 3) == 0) available = NB'($urandom);
      tick();
    end
    hit_valid = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
